// File: rtl/uart_rx_baud_ctrl.sv
// Bit-rate controller for the UART receiver. It calibrates cycles_per_bit from a
// 0x55 sync character and buffers received bytes in a small valid/ready FIFO.
module uart_rx_baud_ctrl #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [15:0] DEFAULT_CPB = 16'd434,
    parameter logic [15:0] MIN_CPB     = 16'd8,
    parameter int unsigned MEAS_W      = 19,
    localparam int unsigned AW = $clog2(FIFO_DEPTH),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          uart_rxd,
    input  logic          cal_start,
    output logic          cal_busy,
    output logic          cal_done,
    output logic          cal_error,
    output logic [15:0]   cycles_per_bit,
    output logic          rx_en,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    input  logic          rx_break,
    output logic          break_det,
    output logic          m_valid,
    output logic [7:0]    m_data,
    input  logic          m_ready,
    output logic [CW-1:0] fifo_count,
    output logic          overflow
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_WAIT_IDLE,
        ST_WAIT_FALL,
        ST_MEASURE,
        ST_SETTLE,
        ST_FAIL
    } state_e;

    localparam logic [MEAS_W-1:0] MEAS_MAX = {MEAS_W{1'b1}};

    state_e            state_q, state_d;
    logic              sync1_q, rxs_q, rxs_d_q;
    logic [16:0]       tmr_q, tmr_d;
    logic [MEAS_W-1:0] meas_q, meas_d;
    logic [1:0]        edges_q, edges_d;
    logic [15:0]       cpb_q, cpb_d;
    logic              cal_done_q, cal_done_d;
    logic              cal_error_q, cal_error_d;
    logic              break_q, break_d;
    logic              overflow_q, overflow_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        mem [FIFO_DEPTH];

    logic              fall;
    logic              ovf_clr;
    logic [MEAS_W:0]   meas_inc;
    logic [15:0]       cpb_new;
    logic [16:0]       settle_last;
    logic              push_req, pop, full, push_ok, drop;

    assign fall        = rxs_d_q && !rxs_q;
    // The counter holds elapsed cycles minus one at the closing edge, hence the +1.
    assign meas_inc    = {1'b0, meas_q} + (MEAS_W + 1)'(1);
    assign cpb_new     = 16'(meas_inc >> 3);
    assign settle_last = {cpb_q, 1'b0} - 17'd1;

    // NOTE: every signal written here gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        meas_d      = meas_q;
        edges_d     = edges_q;
        cpb_d       = cpb_q;
        cal_done_d  = 1'b0;
        cal_error_d = 1'b0;
        ovf_clr     = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (cal_start) begin
                    state_d = ST_WAIT_IDLE;
                    tmr_d   = 17'd0;
                    ovf_clr = 1'b1;
                end
            end
            ST_WAIT_IDLE: begin
                if (!rxs_q) begin
                    tmr_d = 17'd0;
                end else if (tmr_q == 17'd15) begin
                    state_d = ST_WAIT_FALL;
                    tmr_d   = 17'd0;
                end else begin
                    tmr_d = tmr_q + 17'd1;
                end
            end
            ST_WAIT_FALL: begin
                if (fall) begin
                    state_d = ST_MEASURE;
                    meas_d  = '0;
                    edges_d = 2'd0;
                end
            end
            ST_MEASURE: begin
                if (meas_q == MEAS_MAX) begin
                    state_d = ST_FAIL;
                end else begin
                    meas_d = meas_q + MEAS_W'(1);
                    // Falls of 0x55 after the start bit: bits 1, 3, 5, 7 -> 8 bit times.
                    if (fall) begin
                        if (edges_q == 2'd3) begin
                            if (cpb_new >= MIN_CPB) begin
                                cpb_d   = cpb_new;
                                state_d = ST_SETTLE;
                                tmr_d   = 17'd0;
                            end else begin
                                state_d = ST_FAIL;
                            end
                        end else begin
                            edges_d = edges_q + 2'd1;
                        end
                    end
                end
            end
            ST_SETTLE: begin
                if (!rxs_q) begin
                    tmr_d = 17'd0;
                end else if (tmr_q == settle_last) begin
                    state_d    = ST_RUN;
                    cal_done_d = 1'b1;
                end else begin
                    tmr_d = tmr_q + 17'd1;
                end
            end
            ST_FAIL: begin
                state_d     = ST_RUN;
                cal_error_d = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        push_req   = rx_valid && !rx_break && (state_q == ST_RUN);
        pop        = (count_q != '0) && m_ready;
        full       = (count_q == CW'(FIFO_DEPTH));
        push_ok    = push_req && (!full || pop);
        drop       = push_req && full && !pop;
        wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q + CW'(push_ok) - CW'(pop);
        overflow_d = (overflow_q && !ovf_clr) || drop;
        break_d    = rx_valid && rx_break;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_RUN;
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            rxs_d_q     <= 1'b1;
            tmr_q       <= 17'd0;
            meas_q      <= '0;
            edges_q     <= 2'd0;
            cpb_q       <= DEFAULT_CPB;
            cal_done_q  <= 1'b0;
            cal_error_q <= 1'b0;
            break_q     <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= uart_rxd;
            rxs_q       <= sync1_q;
            rxs_d_q     <= rxs_q;
            tmr_q       <= tmr_d;
            meas_q      <= meas_d;
            edges_q     <= edges_d;
            cpb_q       <= cpb_d;
            cal_done_q  <= cal_done_d;
            cal_error_q <= cal_error_d;
            break_q     <= break_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= rx_data;
        end
    end

    assign cal_busy       = (state_q != ST_RUN);
    assign rx_en          = (state_q == ST_RUN);
    assign cal_done       = cal_done_q;
    assign cal_error      = cal_error_q;
    assign cycles_per_bit = cpb_q;
    assign break_det      = break_q;
    assign overflow       = overflow_q;
    assign fifo_count     = count_q;
    assign m_valid        = (count_q != '0);
    assign m_data         = (count_q != '0) ? mem[rd_ptr_q] : 8'h00;

endmodule

// File: tb/tb_uart_rx_baud_ctrl.sv
// Self-checking bench for uart_rx_baud_ctrl: FIFO vector table, calibration
// sequences with timing derived from the pin waveform, and a random stream vs a queue model.
module tb_uart_rx_baud_ctrl;

    localparam int DEPTH  = 4;
    localparam int MEAS_W = 14;
    localparam int CW     = 3;

    logic          clk;
    logic          resetn;
    logic          uart_rxd;
    logic          cal_start;
    logic          cal_busy;
    logic          cal_done;
    logic          cal_error;
    logic [15:0]   cycles_per_bit;
    logic          rx_en;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_break;
    logic          break_det;
    logic          m_valid;
    logic [7:0]    m_data;
    logic          m_ready;
    logic [CW-1:0] fifo_count;
    logic          overflow;

    uart_rx_baud_ctrl #(
        .FIFO_DEPTH (DEPTH),
        .DEFAULT_CPB(16'd434),
        .MIN_CPB    (16'd8),
        .MEAS_W     (MEAS_W)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .uart_rxd      (uart_rxd),
        .cal_start     (cal_start),
        .cal_busy      (cal_busy),
        .cal_done      (cal_done),
        .cal_error     (cal_error),
        .cycles_per_bit(cycles_per_bit),
        .rx_en         (rx_en),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_break      (rx_break),
        .break_det     (break_det),
        .m_valid       (m_valid),
        .m_data        (m_data),
        .m_ready       (m_ready),
        .fifo_count    (fifo_count),
        .overflow      (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    int cyc      = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int done_cyc = 0;
    int err_cyc  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (cal_done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (cal_error) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One 0x55 frame on the pin, LSB first; the line is left in the stop state.
    task automatic send_55(input int bitlen);
        logic [9:0] frame;
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 9; i++) begin
            uart_rxd = frame[i];
            repeat (bitlen) tick();
        end
        uart_rxd = 1'b1;
    endtask

    task automatic start_cal(input bit inject);
        cal_start = 1'b1;
        tick();
        cal_start = 1'b0;
        check("cal_busy_after_start", cal_busy, 1'b1);
        check("rx_en_during_cal", rx_en, 1'b0);
        check("overflow_cleared", overflow, 1'b0);
        uart_rxd = 1'b1;
        for (int i = 0; i < 24; i++) begin
            rx_valid = 1'b0;
            rx_break = 1'b0;
            if (inject && i == 2) begin
                rx_valid = 1'b1;
                rx_data  = 8'hA5;
            end
            if (inject && i == 5) begin
                rx_valid = 1'b1;
                rx_break = 1'b1;
            end
            tick();
            if (inject && i == 5) check("break_in_cal", break_det, 1'b1);
        end
        rx_valid = 1'b0;
        rx_break = 1'b0;
        if (inject) begin
            check("no_push_in_cal", fifo_count, 0);
            check("no_valid_in_cal", m_valid, 1'b0);
        end
    endtask

    task automatic calibrate(input int bitlen, input bit ok, input logic [15:0] exp_cpb,
                             input bit inject);
        int d0, e0, c0, waited;
        d0 = done_cnt;
        e0 = err_cnt;
        start_cal(inject);
        send_55(bitlen);
        c0 = cyc;
        waited = 0;
        while (done_cnt == d0 && err_cnt == e0 && waited < 4 * bitlen + 64) begin
            tick();
            waited++;
        end
        repeat (4) tick();
        if (ok) begin
            check($sformatf("done_pulses_b%0d", bitlen), done_cnt - d0, 1);
            check($sformatf("err_pulses_b%0d", bitlen), err_cnt - e0, 0);
            // Two synchroniser flops, then 2*bitlen high cycles, then the registered pulse.
            check($sformatf("done_time_b%0d", bitlen), done_cyc - c0, 2 * bitlen + 2);
        end else begin
            check($sformatf("err_pulses_b%0d", bitlen), err_cnt - e0, 1);
            check($sformatf("done_pulses_b%0d", bitlen), done_cnt - d0, 0);
        end
        check($sformatf("cpb_after_b%0d", bitlen), cycles_per_bit, exp_cpb);
        check($sformatf("rx_en_after_b%0d", bitlen), rx_en, 1'b1);
        check($sformatf("busy_after_b%0d", bitlen), cal_busy, 1'b0);
    endtask

    typedef struct {
        logic       v;
        logic       b;
        logic [7:0] d;
        logic       r;
        int         cnt;
        logic       mv;
        logic [7:0] md;
        logic       ov;
        logic       bk;
    } vec_t;

    vec_t tbl[15];
    byte unsigned q[$];
    logic mdl_ov;

    initial begin
        int e0, c0, waited, bl;
        logic v, b, r, pop_m;
        logic [7:0] d;

        resetn = 1'b0; uart_rxd = 1'b1; cal_start = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00; rx_break = 1'b0; m_ready = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        tick();

        check("rst_cpb", cycles_per_bit, 16'd434);
        check("rst_rx_en", rx_en, 1'b1);
        check("rst_busy", cal_busy, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_m_data", m_data, 8'h00);
        check("rst_break", break_det, 1'b0);

        //           v     b     d      r      cnt mv    md     ov    bk
        tbl[0]  = '{1'b1, 1'b0, 8'h11, 1'b0, 1, 1'b1, 8'h11, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h22, 1'b0, 2, 1'b1, 8'h11, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h33, 1'b0, 3, 1'b1, 8'h11, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h44, 1'b0, 4, 1'b1, 8'h11, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 8'h55, 1'b1, 4, 1'b1, 8'h22, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 8'h66, 1'b0, 4, 1'b1, 8'h22, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 3, 1'b1, 8'h33, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b1, 2, 1'b1, 8'h44, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h55, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 8'h77, 1'b1, 1, 1'b1, 8'h77, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 8'h00, 1'b0, 1, 1'b1, 8'h77, 1'b1, 1'b1};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1, 1'b0};

        for (int i = 0; i < 15; i++) begin
            rx_valid = tbl[i].v;
            rx_break = tbl[i].b;
            rx_data  = tbl[i].d;
            m_ready  = tbl[i].r;
            tick();
            check($sformatf("vec%0d_count", i), fifo_count, tbl[i].cnt);
            check($sformatf("vec%0d_m_valid", i), m_valid, tbl[i].mv);
            if (tbl[i].mv) check($sformatf("vec%0d_m_data", i), m_data, tbl[i].md);
            check($sformatf("vec%0d_overflow", i), overflow, tbl[i].ov);
            check($sformatf("vec%0d_break", i), break_det, tbl[i].bk);
        end
        rx_valid = 1'b0; rx_break = 1'b0; m_ready = 1'b0;

        calibrate(100, 1'b1, 16'd100, 1'b1);
        calibrate(4, 1'b0, 16'd100, 1'b0);

        // Line held low after the start fall: the measure counter saturates.
        e0 = err_cnt;
        start_cal(1'b0);
        uart_rxd = 1'b0;
        c0 = cyc;
        waited = 0;
        while (err_cnt == e0 && waited < (1 << MEAS_W) + 64) begin
            tick();
            waited++;
        end
        tick();
        check("sat_err_pulses", err_cnt - e0, 1);
        check("sat_err_time", err_cyc - c0, (1 << MEAS_W) + 4);
        check("sat_cpb_kept", cycles_per_bit, 16'd100);
        check("sat_rx_en", rx_en, 1'b1);
        uart_rxd = 1'b1;
        repeat (4) tick();

        for (int k = 0; k < 3; k++) begin
            bl = $urandom_range(8, 48);
            calibrate(bl, 1'b1, 16'(bl), 1'b0);
        end

        q.delete();
        mdl_ov = 1'b0;
        check("rand_start_count", fifo_count, 0);
        check("rand_start_overflow", overflow, 1'b0);
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 99) < 60);
            b = v && ($urandom_range(0, 9) == 0);
            d = 8'($urandom);
            r = ($urandom_range(0, 99) < 45);
            rx_valid = v; rx_break = b; rx_data = d; m_ready = r;
            tick();
            pop_m = (q.size() != 0) && r;
            if (pop_m) void'(q.pop_front());
            if (v && !b) begin
                if (q.size() < DEPTH) q.push_back(d);
                else mdl_ov = 1'b1;
            end
            check($sformatf("rand%0d_count", i), fifo_count, q.size());
            check($sformatf("rand%0d_m_valid", i), m_valid, q.size() != 0);
            if (q.size() != 0) check($sformatf("rand%0d_m_data", i), m_data, q[0]);
            check($sformatf("rand%0d_overflow", i), overflow, mdl_ov);
            check($sformatf("rand%0d_break", i), break_det, v && b);
        end
        rx_valid = 1'b0; rx_break = 1'b0; m_ready = 1'b0;
        tick();

        // Drain, queue two bytes, then reset during MEASURE.
        m_ready = 1'b1;
        repeat (DEPTH + 1) tick();
        m_ready = 1'b0;
        rx_valid = 1'b1; rx_data = 8'hC1; tick();
        rx_data = 8'hC2; tick();
        rx_valid = 1'b0;
        check("pre_reset_count", fifo_count, 2);
        start_cal(1'b0);
        uart_rxd = 1'b0;
        repeat (10) tick();
        check("pre_reset_busy", cal_busy, 1'b1);
        resetn = 1'b0;
        tick();
        check("mid_reset_busy", cal_busy, 1'b0);
        check("mid_reset_rx_en", rx_en, 1'b1);
        check("mid_reset_count", fifo_count, 0);
        check("mid_reset_m_valid", m_valid, 1'b0);
        check("mid_reset_cpb", cycles_per_bit, 16'd434);
        resetn = 1'b1;
        uart_rxd = 1'b1;
        repeat (3) tick();
        check("post_reset_busy", cal_busy, 1'b0);
        check("post_reset_cpb", cycles_per_bit, 16'd434);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_baud_ctrl.md
Name: uart_rx_baud_ctrl

Overview:
- Controller that sits beside the UART receiver and owns its bit-rate configuration and its output stream.
- Auto-calibrates `cycles_per_bit` by timing a 0x55 sync character on the raw pin.
- Gates the receiver enable while calibrating.
- Buffers received bytes in a small FIFO with a valid/ready consumer interface.

Parameters:
- FIFO_DEPTH, 4, number of byte entries in the output FIFO (power of two, ≥2).
- DEFAULT_CPB, 16'd434, `cycles_per_bit` value after reset.
- MIN_CPB, 16'd8, smallest accepted calibration result; smaller results are errors.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- uart_rxd  in  1  raw UART pin (asynchronous), used for measurement
- cal_start  in  1  single-cycle request to run calibration
- cal_busy  out  1  high while calibration is in progress
- cal_done  out  1  single-cycle pulse when calibration succeeds
- cal_error  out  1  single-cycle pulse when calibration fails
- cycles_per_bit  out  16  receiver bit period in clk cycles
- rx_en  out  1  receiver enable
- rx_valid  in  1  receiver byte strobe
- rx_data  in  8  receiver byte
- rx_break  in  1  receiver break flag, qualified by rx_valid
- break_det  out  1  single-cycle pulse, registered from rx_valid&&rx_break
- m_valid  out  1  FIFO head valid
- m_data  out  8  FIFO head byte
- m_ready  in  1  consumer accepts head
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:

Reset values:
- `cycles_per_bit` = DEFAULT_CPB, `rx_en` = 1.
- `cal_busy`, `cal_done`, `cal_error`, `break_det`, `m_valid`, `overflow` = 0.
- `fifo_count` = 0, `m_data` = 0.
- FSM in RUN.

Pin input:
- `uart_rxd` passes through a 2-FF synchroniser (reset to 1) to give `rxs`.
- A falling edge is `rxs_d` && !`rxs`.

FSM states:
- RUN: `rx_en` = 1. `cal_start` → WAIT_IDLE, and clears `overflow` on the same edge. `cal_start` in any other state is ignored.
- WAIT_IDLE: `rx_en` = 0. Wait for `rxs` = 1 continuously for 16 cycles → WAIT_FALL.
- WAIT_FALL: on a falling edge, clear the 19-bit measure counter and the edge counter → MEASURE.
- MEASURE: count one per cycle, saturating at 19'h7FFFF.
  - Count falling edges. 0x55 LSB-first gives falls at the start bit and at bits 1, 3, 5, 7, so the 4th additional fall marks 8 bit times.
  - On that fall: `cpb_new` = (count + 1) >> 3, truncated to 16 bits.
  - If `cpb_new` ≥ MIN_CPB and the counter never saturated: load `cycles_per_bit` and go to SETTLE.
  - Otherwise go to FAIL.
  - If the counter saturates before the 4th fall: go to FAIL.
- SETTLE: wait for `rxs` high continuously for 2×`cycles_per_bit` cycles (stop bit plus margin), then pulse `cal_done` for one cycle → RUN.
- FAIL: keep the previous `cycles_per_bit`, pulse `cal_error` for one cycle → RUN.
- `cal_busy` = (state ≠ RUN).

Receive path and FIFO:
- Push when `rx_valid` && !`rx_break` && state == RUN. Bytes arriving while not in RUN are discarded silently.
- `rx_valid` && `rx_break`: byte not pushed; `break_det` pulses the next cycle, in any state.
- Circular FIFO with read/write pointers and a count.
  - `m_valid` = (count ≠ 0); `m_data` = mem[rd_ptr], registered or combinational from the registered memory.
  - Latency: a byte pushed at edge t is visible on `m_data`/`m_valid` after edge t; no bypass.
- Pop when `m_valid` && `m_ready`.
- Full and push without pop: byte dropped, `overflow` set; count unchanged.
- Full with simultaneous push and pop: both performed, count unchanged, no overflow.
- Empty with simultaneous push: push only; `m_ready` is ignored.
- Pointers wrap modulo FIFO_DEPTH.
- `overflow` stays set until `cal_start` is accepted or reset.

Reset mid-operation:
- Reset mid-calibration or mid-stream restores all reset values.
- FIFO contents are discarded and `cycles_per_bit` reverts to DEFAULT_CPB.

Test Plan:
1. Reset, then idle: `cycles_per_bit` = 434, `rx_en` = 1, `m_valid` = 0, `fifo_count` = 0.
2. `cal_start`, then send 0x55 at 100 clk/bit: `rx_en` = 0 during calibration; `cal_done` pulses after stop bit + 200 high cycles; `cycles_per_bit` = 100; `rx_en` = 1.
3. `cal_start` with a 4-clk/bit 0x55: `cal_error` pulses; `cycles_per_bit` stays 100. Then `cal_start` with the line held low: saturation → `cal_error`.
4. Push 0x11, 0x22, 0x33, 0x44, 0x55 with `m_ready` = 0 (FIFO_DEPTH 4): `fifo_count` = 4, `overflow` = 1, 0x55 dropped. Raise `m_ready`: pop order is 0x11..0x44. Push on the cycle full with `m_ready` = 1: accepted, no drop.
5. `rx_valid` with `rx_break` = 1 and `rx_data` = 0x00: `break_det` pulses one cycle, `fifo_count` unchanged. `rx_valid` during calibration: not pushed.
6. Assert `resetn` low during MEASURE with 2 bytes queued: next cycle state RUN, `fifo_count` = 0, `cycles_per_bit` = 434.
